seg7_capture_to_bcd: RTL and testbench
======================================

// Module: seg7_capture_to_bcd
// PURPOSE
//  Receiving end of the 7-segment display interface: samples the active-low segment bus and
//  active-low digit selects driven by our display drivers, waits for a stable pattern, and
//  decodes it back to a BCD digit plus decimal point per digit position.
//  Used as an on-board loopback monitor / self-checker beside the display drivers.
// PARAMETERS
//  NUM_DIGITS     4     number of digit positions (sel_n width); 1 for the single-digit board
//  STABLE_CYCLES  1000  clk cycles a {seg,dp,sel} snapshot must hold before capture (>=2)
//  CNT_W          16    stability counter width; must hold STABLE_CYCLES-1
// PORTS
//  clk          in   1             system clock (single clock domain)
//  rst          in   1             synchronous, active-high reset
//  seg_n        in   7             segment cathodes, active-low, bit0=a .. bit6=g
//  dp_n         in   1             decimal point, active-low
//  sel_n        in   NUM_DIGITS    digit selects, active-low, one-hot-low when driven
//  bcd_out      out  4*NUM_DIGITS  decoded digit i in bits [4i+3:4i]
//  dp_out       out  NUM_DIGITS    captured decimal point per digit, active-high
//  digit_valid  out  NUM_DIGITS    1 = bcd_out nibble holds a decoded digit
//  update       out  1             1-cycle pulse: a digit was written
//  err_invalid  out  1             1-cycle pulse: stable pattern was not a legal digit
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): bcd_out=0, dp_out=0, digit_valid=0, update=0,
//    err_invalid=0, FSM=IDLE, counter=0, sync flops load inactive (seg_n/dp_n/sel_n all 1).
//    Reset mid-SETTLE/HOLD abandons the capture; no pulse is issued.
//  - All inputs pass a 2-flop synchronizer; "snapshot" = synchronized {sel_n,dp_n,seg_n}.
//  - Decode: invert to active-high {g..a}: 3F=0 06=1 5B=2 4F=3 66=4 6D=5 7D|7C=6 07|27=7
//    7F=8 6F|67=9; 00 = blank; every other value is illegal.
//  - FSM:
//    IDLE   : no sel or >1 sel active -> stay; exactly one active -> SETTLE, counter=0.
//    SETTLE : snapshot != previous snapshot -> counter=0 (restart; to IDLE if sel not one-hot);
//             else counter++; at counter==STABLE_CYCLES-1 -> CAPTURE.
//    CAPTURE: one cycle; for selected digit k: legal -> nibble k=value, dp_out[k]=~dp_n,
//             digit_valid[k]=1, update=1; blank -> nibble k=4'hF, digit_valid[k]=0, update=1;
//             illegal -> outputs unchanged, err_invalid=1. -> HOLD.
//    HOLD   : snapshot unchanged -> stay (no re-capture); changed -> SETTLE (counter=0) or IDLE.
//  - Latency: input pins stable from cycle 0 => update/err_invalid high in cycle STABLE_CYCLES+3
//    (2 sync + STABLE_CYCLES count + 1 registered output), one cycle only.
//  - Multiplexed scan: each digit is re-captured each time its select window exceeds
//    STABLE_CYCLES; windows shorter than that are ignored (no pulse, no change).
//  - update and err_invalid are mutually exclusive; counter saturates, never wraps.
//  - Untouched digits keep their last value; only reset clears digit_valid.
// STRUCTURE
//  - seg7_defs.vh (shared): segment pattern constants, blank code 4'hF, FSM state encodings
//    (IDLE/SETTLE/CAPTURE/HOLD); reused by the display drivers' encoders.
//  - Sub-module seg7_pattern_decode: combinational {g..a} -> {legal, blank, bcd[3:0]}.
//  - Top: synchronizer, snapshot/compare register, stability counter, FSM, output registers.
// TESTING (NUM_DIGITS=4, STABLE_CYCLES=4)
//  1 rst=1 for 2 cycles, all inputs released -> all outputs 0, no pulses for 20 cycles.
//  2 sel_n=4'b1110, seg_n=~7'h4F, dp_n=0 held -> update in cycle 7; bcd_out[3:0]=3,
//    dp_out[0]=1, digit_valid=4'b0001; no further pulse while held.
//  3 scan digits 0..3 with 7'h3F,06,5B,7C, 10-cycle windows -> bcd_out=16'h6210,
//    digit_valid=4'hF, exactly 4 update pulses.
//  4 seg_n=~7'h49 on digit 2 -> err_invalid one pulse, digit 2 nibble/valid unchanged;
//    then seg_n=7'h7F (blank) -> update, nibble 2=F, digit_valid[2]=0.
//  5 glitch: pattern toggles every 3 cycles, or sel_n=4'b1100 -> no update/err ever.
//  6 rst asserted in SETTLE cycle 2 of a legal pattern -> no pulse, outputs 0; after release
//    the still-held pattern is captured STABLE_CYCLES+3 cycles later.

Source files
------------

// File: rtl/seg7_capture_to_bcd_pkg.sv
// Shared definitions for the 7-segment capture path.
// Contents:
//   cap_state_t : capture FSM states.
//   BLANK_CODE  : nibble value reported for a blank (all segments off) digit.
//   SEG_*       : active-high {g..a} patterns for each digit, including the
//                 alternate 6/7/9 shapes that some encoders produce.
package seg7_capture_to_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } cap_state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_6_ALT = 7'h7C;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_7_ALT = 7'h27;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_9_ALT = 7'h67;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-high segment pattern back to BCD.
// Ports:
//   seg   in  7  active-high segments, bit0=a .. bit6=g
//   legal out 1  pattern is one of the ten digit shapes
//   blank out 1  pattern is all segments off
//   bcd   out 4  decoded digit (BLANK_CODE when blank, 0 when illegal)
// A pattern that is neither legal nor blank is an illegal capture.
module seg7_pattern_decode
  import seg7_capture_to_bcd_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] bcd
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    legal = 1'b1;
    blank = 1'b0;
    bcd   = 4'd0;
    case (seg)
      SEG_0:                bcd = 4'd0;
      SEG_1:                bcd = 4'd1;
      SEG_2:                bcd = 4'd2;
      SEG_3:                bcd = 4'd3;
      SEG_4:                bcd = 4'd4;
      SEG_5:                bcd = 4'd5;
      SEG_6, SEG_6_ALT:     bcd = 4'd6;
      SEG_7, SEG_7_ALT:     bcd = 4'd7;
      SEG_8:                bcd = 4'd8;
      SEG_9, SEG_9_ALT:     bcd = 4'd9;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
        bcd   = BLANK_CODE;
      end
      default:              legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture_to_bcd.sv
// Receiving end of the multiplexed 7-segment display bus. Synchronizes the
// active-low segment/dp/select pins, waits until a single-digit pattern has
// been stable for STABLE_CYCLES clocks, then decodes it into that digit's
// BCD nibble and decimal point.
// Ports:
//   clk          in   1             system clock
//   rst          in   1             synchronous, active-high reset
//   seg_n        in   7             segments, active-low, bit0=a .. bit6=g
//   dp_n         in   1             decimal point, active-low
//   sel_n        in   NUM_DIGITS    digit selects, active-low
//   bcd_out      out  4*NUM_DIGITS  digit i in bits [4i+3:4i]
//   dp_out       out  NUM_DIGITS    captured decimal point, active-high
//   digit_valid  out  NUM_DIGITS    nibble holds a decoded digit
//   update       out  1             one-cycle pulse: a digit was written
//   err_invalid  out  1             one-cycle pulse: stable pattern illegal
module seg7_capture_to_bcd
  import seg7_capture_to_bcd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 16
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic                    dp_n,
  input  logic [NUM_DIGITS-1:0]   sel_n,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic                    err_invalid
);

  typedef struct packed {
    logic [NUM_DIGITS-1:0] sel_n;
    logic                  dp_n;
    logic [6:0]            seg_n;
  } snap_t;

  // The counter starts at 0 on the first cycle the pattern is seen, so the
  // last compare before capture happens at STABLE_CYCLES-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  snap_t            sync1;
  snap_t            snap;
  snap_t            prev;
  cap_state_t       state;
  logic [CNT_W-1:0] cnt;

  logic             snap_changed;
  logic             snap_onehot;
  logic             dec_legal;
  logic             dec_blank;
  logic [3:0]       dec_bcd;

  assign snap_changed = (snap != prev);
  assign snap_onehot  = $onehot(~snap.sel_n);

  // prev holds the pattern that has just been proven stable, so capture
  // decodes it rather than the live snapshot.
  seg7_pattern_decode u_decode (
    .seg   (~prev.seg_n),
    .legal (dec_legal),
    .blank (dec_blank),
    .bcd   (dec_bcd)
  );

  // Two-flop synchronizer plus the one-cycle-old copy used for change detect.
  // Reset loads the idle bus level (everything inactive-high).
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every flop samples
    // the pre-edge value of its source, independent of statement order.
    if (rst) begin
      sync1 <= '1;
      snap  <= '1;
      prev  <= '1;
    end else begin
      sync1 <= snap_t'({sel_n, dp_n, seg_n});
      snap  <= sync1;
      prev  <= snap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bcd_out     <= '0;
      dp_out      <= '0;
      digit_valid <= '0;
      update      <= 1'b0;
      err_invalid <= 1'b0;
    end else begin
      update      <= 1'b0;
      err_invalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (snap_onehot) begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end
        end

        ST_SETTLE: begin
          if (snap_changed) begin
            cnt <= '0;
            if (!snap_onehot) state <= ST_IDLE;
          end else begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) state <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!prev.sel_n[i]) begin
              if (dec_legal) begin
                bcd_out[4*i +: 4] <= dec_bcd;
                dp_out[i]         <= ~prev.dp_n;
                digit_valid[i]    <= 1'b1;
              end else if (dec_blank) begin
                bcd_out[4*i +: 4] <= BLANK_CODE;
                digit_valid[i]    <= 1'b0;
              end
            end
          end
          update      <= dec_legal | dec_blank;
          err_invalid <= ~(dec_legal | dec_blank);
          // A pattern change landing in this very cycle starts a new settle
          // window immediately; otherwise HOLD would compare against the new
          // value and miss the change.
          if (snap_changed) begin
            cnt   <= '0;
            state <= snap_onehot ? ST_SETTLE : ST_IDLE;
          end else begin
            state <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (snap_changed) begin
            cnt   <= '0;
            state <= snap_onehot ? ST_SETTLE : ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_capture_to_bcd.sv
// Bench for seg7_capture_to_bcd with NUM_DIGITS=4, STABLE_CYCLES=4.
// The reference model sees the pins as a per-cycle history: the synchronized
// snapshot is the pin value two cycles earlier (forced idle around reset),
// and a digit is captured in the cycle S+1 after the start of a run of
// exactly-identical one-hot snapshots that reaches length S.
module tb_seg7_capture_to_bcd;

  localparam int ND    = 4;
  localparam int S     = 4;
  localparam int MAXE  = 4096;

  logic          clk;
  logic          rst;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [ND-1:0] sel_n;
  logic [4*ND-1:0] bcd_out;
  logic [ND-1:0] dp_out;
  logic [ND-1:0] digit_valid;
  logic          update;
  logic          err_invalid;

  seg7_capture_to_bcd #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (S),
    .CNT_W         (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .sel_n       (sel_n),
    .bcd_out     (bcd_out),
    .dp_out      (dp_out),
    .digit_valid (digit_valid),
    .update      (update),
    .err_invalid (err_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_upd    = 0;
  int n_err    = 0;

  // Pin/snapshot history, indexed by clock edge.
  logic [ND+7:0] s_hist [0:MAXE-1];
  bit            r_hist [0:MAXE-1];
  logic [ND+7:0] p_prev;
  int            edge_idx = 0;

  // Reference output state.
  logic [4*ND-1:0] m_bcd   = '0;
  logic [ND-1:0]   m_dp    = '0;
  logic [ND-1:0]   m_valid = '0;
  logic            m_upd   = 1'b0;
  logic            m_err   = 1'b0;

  logic [6:0] legal_pats [0:13];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_idx);
    end
  endtask

  // Digit value for an active-high pattern: 0..9, 16 for blank, -1 illegal.
  function automatic int ref_digit(input logic [6:0] hi);
    case (hi)
      7'h3F:        return 0;
      7'h06:        return 1;
      7'h5B:        return 2;
      7'h4F:        return 3;
      7'h66:        return 4;
      7'h6D:        return 5;
      7'h7D, 7'h7C: return 6;
      7'h07, 7'h27: return 7;
      7'h7F:        return 8;
      7'h6F, 7'h67: return 9;
      7'h00:        return 16;
      default:      return -1;
    endcase
  endfunction

  task automatic model_edge(input int t);
    logic [ND+7:0] v;
    bit ok;
    int k;
    int d;
    m_upd = 1'b0;
    m_err = 1'b0;
    if (r_hist[t]) begin
      m_bcd = '0; m_dp = '0; m_valid = '0;
      return;
    end
    if (t < S + 2 || r_hist[t-1]) return;
    v  = s_hist[t-2];
    ok = $onehot(~v[ND+7:8]);
    for (int j = 1; j < S; j++)
      if (s_hist[t-2-j] != v) ok = 0;
    if (s_hist[t-2-S] == v) ok = 0;
    if (!ok) return;
    k = 0;
    for (int j = 0; j < ND; j++)
      if (!v[8+j]) k = j;
    d = ref_digit(~v[6:0]);
    if (d >= 0 && d < 10) begin
      m_bcd[4*k +: 4] = 4'(d);
      m_dp[k]         = ~v[7];
      m_valid[k]      = 1'b1;
      m_upd           = 1'b1;
    end else if (d == 16) begin
      m_bcd[4*k +: 4] = 4'hF;
      m_valid[k]      = 1'b0;
      m_upd           = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // One clock: record pins at the edge, advance the model, compare on the
  // falling edge.
  task automatic step();
    logic [ND+7:0] pins;
    @(posedge clk);
    if (edge_idx >= MAXE) begin
      $display("FAIL history: edge budget %0d exhausted", MAXE);
      $fatal(1, "edge budget exhausted");
    end
    pins = {sel_n, dp_n, seg_n};
    r_hist[edge_idx] = rst;
    if (rst || edge_idx == 0 || r_hist[edge_idx-1]) s_hist[edge_idx] = '1;
    else                                            s_hist[edge_idx] = p_prev;
    model_edge(edge_idx);
    p_prev = pins;
    @(negedge clk);
    check("bcd_out", 32'(bcd_out), 32'(m_bcd));
    check("dp_out", 32'(dp_out), 32'(m_dp));
    check("digit_valid", 32'(digit_valid), 32'(m_valid));
    check("update", 32'(update), 32'(m_upd));
    check("err_invalid", 32'(err_invalid), 32'(m_err));
    if (update) n_upd++;
    if (err_invalid) n_err++;
    edge_idx++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    legal_pats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                   7'h7C, 7'h07, 7'h27, 7'h7F, 7'h6F, 7'h67, 7'h00};
    rst = 1'b1; seg_n = '1; dp_n = 1'b1; sel_n = '1; p_prev = '1;

    // 1: reset, then idle bus.
    steps(2);
    rst = 1'b0;
    n_upd = 0; n_err = 0;
    steps(20);
    check("t1_outputs", 32'({bcd_out, dp_out, digit_valid}), 32'd0);
    check("t1_pulses", 32'(n_upd + n_err), 32'd0);

    // 2: single held digit, capture latency S+3.
    sel_n = 4'b1110; seg_n = ~7'h4F; dp_n = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      step();
      check("t2_update_timing", 32'(update), 32'(c == 7));
    end
    check("t2_nibble0", 32'(bcd_out[3:0]), 32'd3);
    check("t2_dp0", 32'(dp_out[0]), 32'd1);
    check("t2_valid", 32'(digit_valid), 32'b0001);
    n_upd = 0;
    steps(10);
    check("t2_no_recapture", 32'(n_upd), 32'd0);

    // 3: multiplexed scan with 10-cycle windows.
    dp_n = 1'b1;
    n_upd = 0;
    sel_n = 4'b1110; seg_n = ~7'h3F; steps(10);
    sel_n = 4'b1101; seg_n = ~7'h06; steps(10);
    sel_n = 4'b1011; seg_n = ~7'h5B; steps(10);
    sel_n = 4'b0111; seg_n = ~7'h7C; steps(10);
    check("t3_bcd", 32'(bcd_out), 32'h6210);
    check("t3_valid", 32'(digit_valid), 32'hF);
    check("t3_updates", 32'(n_upd), 32'd4);

    // 4: illegal then blank on digit 2.
    n_upd = 0; n_err = 0;
    sel_n = 4'b1011; seg_n = ~7'h49; steps(10);
    check("t4_err_count", 32'(n_err), 32'd1);
    check("t4_upd_none", 32'(n_upd), 32'd0);
    check("t4_bcd_kept", 32'(bcd_out), 32'h6210);
    check("t4_valid_kept", 32'(digit_valid), 32'hF);
    seg_n = 7'h7F; steps(10);
    check("t4_blank_upd", 32'(n_upd), 32'd1);
    check("t4_blank_bcd", 32'(bcd_out), 32'h6F10);
    check("t4_blank_valid", 32'(digit_valid), 32'b1011);

    // 5: glitching pattern and multi-select never capture.
    n_upd = 0; n_err = 0;
    sel_n = 4'b1101;
    for (int g = 0; g < 8; g++) begin
      seg_n = (g % 2 == 0) ? ~7'h3F : ~7'h06;
      steps(3);
    end
    sel_n = 4'b1100; seg_n = ~7'h7F; steps(12);
    check("t5_no_pulses", 32'(n_upd + n_err), 32'd0);
    check("t5_bcd_kept", 32'(bcd_out), 32'h6F10);

    // 6: reset in the middle of settling.
    sel_n = 4'b0111; seg_n = ~7'h07; dp_n = 1'b1;
    n_upd = 0;
    steps(3);
    rst = 1'b1; step();
    rst = 1'b0;
    check("t6_reset_outputs", 32'({bcd_out, dp_out, digit_valid}), 32'd0);
    check("t6_reset_no_pulse", 32'(n_upd), 32'd0);
    for (int c = 1; c <= S + 3; c++) begin
      step();
      check("t6_update_timing", 32'(update), 32'(c == S + 3));
    end
    check("t6_bcd", 32'(bcd_out), 32'h7000);
    check("t6_valid", 32'(digit_valid), 32'b1000);

    // Randomized windows against the model.
    for (int w = 0; w < 250; w++) begin
      if ($urandom_range(0, 99) < 80) sel_n = ~(4'b0001 << $urandom_range(0, ND-1));
      else                            sel_n = 4'($urandom);
      case ($urandom_range(0, 9))
        0, 1:    seg_n = 7'($urandom);
        default: seg_n = ~legal_pats[$urandom_range(0, 13)];
      endcase
      dp_n = 1'($urandom);
      rst  = ($urandom_range(0, 99) < 3);
      step();
      rst  = 1'b0;
      steps($urandom_range(0, 11));
    end
    steps(S + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
